// File: rtl/vga_pattern_sched_if.sv
// rtl/vga_pattern_sched_if.sv - button/frame inputs and pattern-selection outputs of the pattern scheduler
interface vga_pattern_sched_if;
  logic       frame_start;
  logic       btn_next;
  logic       btn_mode;
  logic [1:0] pattern_sel;
  logic       blank;
  logic       auto_mode;
  logic [3:0] led;
  logic       switch_pulse;

  modport master (
    input  frame_start, btn_next, btn_mode,
    output pattern_sel, blank, auto_mode, led, switch_pulse
  );

  modport slave (
    output frame_start, btn_next, btn_mode,
    input  pattern_sel, blank, auto_mode, led, switch_pulse
  );
endinterface

// File: rtl/vga_pattern_sched.sv
// rtl/vga_pattern_sched.sv - frame-aligned VGA test-pattern scheduler with debounced buttons and black-frame switching
module vga_pattern_sched #(
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int DEBOUNCE_CYCLES    = 250000,
  parameter int BLANK_FRAMES       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_pattern_sched_if.master  bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FW = $clog2(FRAMES_PER_PATTERN + 1);
  localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

  typedef enum logic [1:0] {SHOW, PENDING, BLANK} state_t;

  // Index 0 is btn_next, index 1 is btn_mode.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1, sync2, acc, acc_q, btn_ev;
  logic [DW-1:0] db_cnt [2];

  assign btn_raw = {bus.btn_mode, bus.btn_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      acc    <= '0;
      acc_q  <= '0;
      btn_ev <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      acc_q  <= acc;
      btn_ev <= acc & ~acc_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          acc[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic next_ev, mode_ev;
  assign next_ev = btn_ev[0];
  assign mode_ev = btn_ev[1];

  state_t        state, state_next;
  logic [FW-1:0] frame_cnt, frame_cnt_d;
  logic [BW-1:0] blank_cnt, blank_cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    led_q, led_d;
  logic          blank_q, blank_d, auto_q, auto_d, pulse_q, pulse_d;
  logic          request, last_blank;

  assign request    = next_ev ||
                      (bus.frame_start && auto_q && frame_cnt == FW'(FRAMES_PER_PATTERN - 1));
  assign last_blank = bus.frame_start && blank_cnt == BW'(BLANK_FRAMES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SHOW;
      frame_cnt <= '0;
      blank_cnt <= '0;
      sel_q     <= '0;
      led_q     <= 4'b0001;
      blank_q   <= 1'b0;
      auto_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_d;
      blank_cnt <= blank_cnt_d;
      sel_q     <= sel_d;
      led_q     <= led_d;
      blank_q   <= blank_d;
      auto_q    <= auto_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SHOW:    if (request) state_next = PENDING;
      PENDING: if (bus.frame_start) state_next = BLANK;
      BLANK:   if (last_blank) state_next = SHOW;
      default: state_next = SHOW;
    endcase
  end

  // Selection, led, blank and pulse all load on the same edge so no frame sees a half-updated pattern.
  always_comb begin
    sel_d       = sel_q;
    led_d       = led_q;
    blank_d     = blank_q;
    pulse_d     = 1'b0;
    auto_d      = auto_q ^ mode_ev;
    frame_cnt_d = frame_cnt;
    blank_cnt_d = blank_cnt;
    case (state)
      SHOW: begin
        if (bus.frame_start && auto_q) frame_cnt_d = frame_cnt + FW'(1);
      end
      PENDING: begin
        if (bus.frame_start) begin
          blank_d     = 1'b1;
          blank_cnt_d = '0;
        end
      end
      BLANK: begin
        if (last_blank) begin
          sel_d       = (sel_q == 2'(NUM_PATTERNS - 1)) ? 2'd0 : sel_q + 2'd1;
          led_d       = 4'b0001 << sel_d;
          blank_d     = 1'b0;
          pulse_d     = 1'b1;
          frame_cnt_d = '0;
        end else if (bus.frame_start) begin
          blank_cnt_d = blank_cnt + BW'(1);
        end
      end
      default: ;
    endcase
    if (mode_ev) frame_cnt_d = '0;
  end

  assign bus.pattern_sel  = sel_q;
  assign bus.led          = led_q;
  assign bus.blank        = blank_q;
  assign bus.auto_mode    = auto_q;
  assign bus.switch_pulse = pulse_q;

endmodule
